// File: rtl/eth_idma_desc_pkg.sv
// Shared types for the Ethernet iDMA descriptor queue: descriptor layout,
// direction encoding and sequencer states.
package eth_idma_desc_pkg;

    localparam int unsigned DescAddrWidth = 32;
    localparam int unsigned DescLenWidth  = 32;

    // Direction: TX reads AXI and writes AXIS, RX reads AXIS and writes AXI.
    localparam logic DirTx = 1'b0;
    localparam logic DirRx = 1'b1;

    typedef struct packed {
        logic [DescLenWidth-1:0]  len;
        logic [DescAddrWidth-1:0] src;
        logic [DescAddrWidth-1:0] dst;
        logic                     dir;
    } desc_t;

    typedef enum logic {
        StRun,
        StFlush
    } state_e;

endpackage

// File: rtl/eth_idma_desc_fifo.sv
// Register-array descriptor FIFO with synchronous flush and occupancy count.
// The head entry is read directly from storage at the read pointer.
module eth_idma_desc_fifo
    import eth_idma_desc_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  desc_t                  wdata,
    output desc_t                  rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(Depth):0] count
);

    localparam int unsigned PtrWidth = $clog2(Depth);

    logic [PtrWidth-1:0] wr_ptr_q;
    logic [PtrWidth-1:0] rd_ptr_q;
    logic [PtrWidth:0]   count_q;
    desc_t               mem_q [Depth];
    logic                do_push;
    logic                do_pop;

    assign full    = (count_q == (PtrWidth+1)'(Depth));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage has no reset; an entry is only observed after it has been
    // written, so resetting the array would only add reset fan-out.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/eth_idma_desc_queue.sv
// Descriptor queue and sequencer in front of the Ethernet iDMA backend:
// buffers pushed descriptors, issues them with an outstanding limit, counts responses.
module eth_idma_desc_queue
    import eth_idma_desc_pkg::*;
#(
    parameter int unsigned AddrWidth      = DescAddrWidth,
    parameter int unsigned TFLenWidth     = DescLenWidth,
    parameter int unsigned Depth          = 4,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned CntWidth       = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            push_i,
    input  logic [TFLenWidth-1:0]           push_len_i,
    input  logic [AddrWidth-1:0]            push_src_i,
    input  logic [AddrWidth-1:0]            push_dst_i,
    input  logic                            push_dir_i,
    output logic                            push_ready_o,
    output logic                            req_valid_o,
    input  logic                            req_ready_i,
    output logic [TFLenWidth-1:0]           req_len_o,
    output logic [AddrWidth-1:0]            req_src_o,
    output logic [AddrWidth-1:0]            req_dst_o,
    output logic                            req_dir_o,
    input  logic                            rsp_valid_i,
    input  logic                            rsp_error_i,
    output logic                            rsp_ready_o,
    input  logic                            flush_i,
    input  logic                            clear_i,
    output logic [$clog2(Depth):0]          pending_o,
    output logic [$clog2(MaxOutstanding):0] outstanding_o,
    output logic [CntWidth-1:0]             done_cnt_o,
    output logic [CntWidth-1:0]             err_cnt_o,
    output logic                            overflow_o,
    output logic                            irq_o,
    output logic                            busy_o
);

    localparam int unsigned OutWidth = $clog2(MaxOutstanding) + 1;

    state_e                state_q, state_d;
    desc_t                 push_desc;
    desc_t                 head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  run;
    logic                  push_acc;
    logic                  push_drop;
    logic                  issue;
    logic                  rsp_acc;
    logic [OutWidth-1:0]   outstanding_q;
    logic [CntWidth-1:0]   done_cnt_q;
    logic [CntWidth-1:0]   err_cnt_q;
    logic                  overflow_q;
    logic                  irq_q;

    assign push_desc = '{len: push_len_i, src: push_src_i, dst: push_dst_i, dir: push_dir_i};

    assign run          = (state_q == StRun);
    assign push_ready_o = run && !fifo_full;
    // A push coinciding with flush_i would be wiped on the same edge, so it is dropped.
    assign push_acc     = push_i && push_ready_o && (push_len_i != '0) && !flush_i;
    assign push_drop    = push_i && !push_acc;

    assign req_valid_o = run && !fifo_empty && (outstanding_q < OutWidth'(MaxOutstanding));
    assign issue       = req_valid_o && req_ready_i;
    assign rsp_acc     = rsp_valid_i && (outstanding_q != '0);
    assign rsp_ready_o = 1'b1;

    eth_idma_desc_fifo #(
        .Depth (Depth)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push_acc),
        .pop    (issue),
        .flush  (flush_i),
        .wdata  (push_desc),
        .rdata  (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (pending_o)
    );

    // Head fields are masked while idle so the request bus reads zero out of reset.
    assign req_len_o = req_valid_o ? head.len : '0;
    assign req_src_o = req_valid_o ? head.src : '0;
    assign req_dst_o = req_valid_o ? head.dst : '0;
    assign req_dir_o = req_valid_o ? head.dir : 1'b0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= StRun;
        else         state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun:   if (flush_i) state_d = StFlush;
            StFlush: if (!flush_i && outstanding_q == '0) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else begin
            case ({issue, rsp_acc})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // Clear zeroes the counters, yet a response on the same edge still lands as 1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_cnt_q <= '0;
            err_cnt_q  <= '0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
        end else if (clear_i) begin
            done_cnt_q <= (rsp_acc && !rsp_error_i) ? CntWidth'(1) : '0;
            err_cnt_q  <= (rsp_acc && rsp_error_i) ? CntWidth'(1) : '0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            if (rsp_acc) begin
                irq_q <= 1'b1;
                if (rsp_error_i) begin
                    if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
                end else begin
                    if (done_cnt_q != '1) done_cnt_q <= done_cnt_q + 1'b1;
                end
            end
            if (push_drop) overflow_q <= 1'b1;
        end
    end

    assign outstanding_o = outstanding_q;
    assign done_cnt_o    = done_cnt_q;
    assign err_cnt_o     = err_cnt_q;
    assign overflow_o    = overflow_q;
    assign irq_o         = irq_q;
    assign busy_o        = (pending_o != '0) || (outstanding_q != '0);

endmodule

// File: tb/tb_eth_idma_desc_queue.sv
// Self-checking bench for eth_idma_desc_queue: issued descriptors are matched
// against a scoreboard queue filled when pushes are driven.
module tb_eth_idma_desc_queue;
    import eth_idma_desc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push_i = 1'b0;
    logic [31:0] push_len_i = '0;
    logic [31:0] push_src_i = '0;
    logic [31:0] push_dst_i = '0;
    logic        push_dir_i = 1'b0;
    logic        push_ready_o;
    logic        req_valid_o;
    logic        req_ready_i = 1'b0;
    logic [31:0] req_len_o;
    logic [31:0] req_src_o;
    logic [31:0] req_dst_o;
    logic        req_dir_o;
    logic        rsp_valid_i = 1'b0;
    logic        rsp_error_i = 1'b0;
    logic        rsp_ready_o;
    logic        flush_i = 1'b0;
    logic        clear_i = 1'b0;
    logic [2:0]  pending_o;
    logic [1:0]  outstanding_o;
    logic [7:0]  done_cnt_o;
    logic [7:0]  err_cnt_o;
    logic        overflow_o;
    logic        irq_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;
    desc_t sb[$];

    eth_idma_desc_queue #(
        .AddrWidth(32), .TFLenWidth(32), .Depth(4), .MaxOutstanding(2), .CntWidth(8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .push_i(push_i), .push_len_i(push_len_i), .push_src_i(push_src_i),
        .push_dst_i(push_dst_i), .push_dir_i(push_dir_i), .push_ready_o(push_ready_o),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_len_o(req_len_o),
        .req_src_o(req_src_o), .req_dst_o(req_dst_o), .req_dir_o(req_dir_o),
        .rsp_valid_i(rsp_valid_i), .rsp_error_i(rsp_error_i), .rsp_ready_o(rsp_ready_o),
        .flush_i(flush_i), .clear_i(clear_i), .pending_o(pending_o),
        .outstanding_o(outstanding_o), .done_cnt_o(done_cnt_o), .err_cnt_o(err_cnt_o),
        .overflow_o(overflow_o), .irq_o(irq_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_desc(input logic [31:0] len, input logic [31:0] src,
                             input logic [31:0] dst, input logic dir, input bit to_sb);
        push_i = 1'b1; push_len_i = len; push_src_i = src; push_dst_i = dst; push_dir_i = dir;
        if (to_sb) sb.push_back('{len: len, src: src, dst: dst, dir: dir});
        cyc();
        push_i = 1'b0;
    endtask

    task automatic respond(input logic err);
        rsp_valid_i = 1'b1; rsp_error_i = err;
        cyc();
        rsp_valid_i = 1'b0; rsp_error_i = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
    endtask

    // Inputs only change just after a rising edge, so a handshake seen here fires next edge.
    always @(negedge clk) begin
        if (rst_n && req_valid_o && req_ready_i) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                desc_t e;
                e = sb.pop_front();
                check("req_len", req_len_o, e.len);
                check("req_src", req_src_o, e.src);
                check("req_dst", req_dst_o, e.dst);
                check("req_dir", req_dir_o, e.dir);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        cyc();

        // Reset values
        check("rst_push_ready", push_ready_o, 1);
        check("rst_rsp_ready", rsp_ready_o, 1);
        check("rst_req_valid", req_valid_o, 0);
        check("rst_req_len", req_len_o, 0);
        check("rst_pending", pending_o, 0);
        check("rst_outstanding", outstanding_o, 0);
        check("rst_cnts", {done_cnt_o, err_cnt_o}, 0);
        check("rst_flags", {overflow_o, irq_o, busy_o}, 0);

        // Single TX descriptor, one-cycle latency to request
        req_ready_i = 1'b1;
        push_desc(32'd64, 32'h1000, 32'h0, DirTx, 1'b1);
        check("t1_req_valid", req_valid_o, 1);
        check("t1_req_len_now", req_len_o, 64);
        cyc();
        check("t1_outstanding", outstanding_o, 1);
        check("t1_req_valid_off", req_valid_o, 0);
        respond(1'b0);
        check("t1_done", done_cnt_o, 1);
        check("t1_irq", irq_o, 1);
        check("t1_busy", busy_o, 0);
        do_clear();

        // Five pushes into a four-entry queue with the backend stalled
        req_ready_i = 1'b0;
        for (int i = 0; i < 5; i++)
            push_desc(32'd100 + i, 32'h2000 + 32'(i) * 32'h10, 32'h3000 + i, DirRx, i < 4);
        check("t2_overflow", overflow_o, 1);
        check("t2_pending", pending_o, 4);
        check("t2_push_ready", push_ready_o, 0);
        req_ready_i = 1'b1;
        rsp_valid_i = 1'b1;
        for (int i = 0; i < 50 && busy_o; i++) cyc();
        rsp_valid_i = 1'b0;
        check("t2_drained", busy_o, 0);
        check("t2_done", done_cnt_o, 4);
        do_clear();

        // Outstanding limit of two
        req_ready_i = 1'b0;
        for (int i = 0; i < 3; i++)
            push_desc(32'd8 << i, 32'h4000 + i, 32'h5000 + i, 1'(i), 1'b1);
        req_ready_i = 1'b1;
        cyc();
        cyc();
        cyc();
        check("t3_req_valid_blocked", req_valid_o, 0);
        check("t3_pending", pending_o, 1);
        check("t3_outstanding", outstanding_o, 2);
        respond(1'b0);
        check("t3_third_valid", req_valid_o, 1);
        cyc();
        check("t3_outstanding2", outstanding_o, 2);
        respond(1'b0);
        respond(1'b0);
        check("t3_outstanding0", outstanding_o, 0);
        check("t3_done", done_cnt_o, 3);
        do_clear();

        // Error response, zero-length drop, clear
        push_desc(32'd16, 32'h6000, 32'h7000, DirTx, 1'b1);
        cyc();
        respond(1'b1);
        check("t4_err", err_cnt_o, 1);
        check("t4_done", done_cnt_o, 0);
        check("t4_irq", irq_o, 1);
        push_desc(32'd0, 32'h1, 32'h2, DirTx, 1'b0);
        check("t4_zero_len_overflow", overflow_o, 1);
        check("t4_zero_len_pending", pending_o, 0);
        do_clear();
        check("t4_cleared", {done_cnt_o, err_cnt_o, 6'b0, overflow_o, irq_o}, 0);

        // Clear and response on the same edge
        push_desc(32'd24, 32'h8000, 32'h9000, DirRx, 1'b1);
        cyc();
        rsp_valid_i = 1'b1; clear_i = 1'b1;
        cyc();
        rsp_valid_i = 1'b0; clear_i = 1'b0;
        check("t4b_done", done_cnt_o, 1);
        check("t4b_irq", irq_o, 0);
        do_clear();

        // Flush with three queued and one outstanding
        push_desc(32'd32, 32'hA000, 32'hB000, DirTx, 1'b1);
        cyc();
        req_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) push_desc(32'd40 + i, 32'hC000, 32'hD000, DirTx, 1'b0);
        check("t5_pending_pre", pending_o, 3);
        check("t5_outstanding_pre", outstanding_o, 1);
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        check("t5_pending_flushed", pending_o, 0);
        check("t5_req_valid", req_valid_o, 0);
        check("t5_push_ready", push_ready_o, 0);
        push_desc(32'd8, 32'hE000, 32'hF000, DirTx, 1'b0);
        check("t5_push_dropped", {overflow_o, 1'b0, pending_o}, 5'b10000);
        req_ready_i = 1'b1;
        cyc();
        check("t5_no_issue", req_valid_o, 0);
        respond(1'b0);
        check("t5_still_flush", push_ready_o, 0);
        cyc();
        check("t5_back_to_run", push_ready_o, 1);
        push_desc(32'd48, 32'h1100, 32'h2200, DirRx, 1'b1);
        check("t5_reissue", req_valid_o, 1);
        cyc();
        respond(1'b0);
        check("t5_done", done_cnt_o, 2);
        check("t5_busy", busy_o, 0);
        do_clear();

        // Counter saturation
        for (int i = 0; i < 257; i++) begin
            push_desc(32'($urandom_range(1, 4096)), $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
            cyc();
            respond(1'b0);
            if (i == 254) check("t6_done_255", done_cnt_o, 255);
        end
        check("t6_done_sat", done_cnt_o, 255);
        check("t6_err", err_cnt_o, 0);
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
